exu_div: RTL and testbench
==========================

EXU_DIV -- requirements
Module: exu_div

Interface
REQ-001 Parameters: none; widths come from the global header: XLEN (32) and REG_FILE_ADDR_WIDTH (5).
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 div_valid  input  1  divide issued this cycle (IDU1 output legal & div).
REQ-005 rs1_data  input  XLEN  dividend.
REQ-006 rs2_data  input  XLEN  divisor.
REQ-007 rs1_sign  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-008 rem  input  1  1 = return remainder, 0 = return quotient.
REQ-009 rd_addr  input  REG_FILE_ADDR_WIDTH  destination register.
REQ-010 pipe_flush  input  1  abort any in-flight divide.
REQ-011 exu_div_busy  output  1  divider occupied; feeds the IDU1 stall logic.
REQ-012 div_wb_valid  output  1  result valid this cycle.
REQ-013 div_wb_data  output  XLEN  quotient or remainder.
REQ-014 div_wb_rd_addr  output  REG_FILE_ADDR_WIDTH  destination for the result.

Function
REQ-015 FSM states: IDLE, CALC, DONE; exu_div_busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-016 Accept: div_valid=1 & state=IDLE & pipe_flush=0 at edge T SHALL latch operands, rs1_sign, rem and rd_addr.
REQ-017 div_valid in CALC or DONE SHALL be ignored; div_valid with pipe_flush=1 SHALL be ignored.
REQ-018 Normal path: IDLE->CALC at T+1; a 5-bit counter runs 32 CALC cycles (T+1..T+32); CALC->DONE at T+33; DONE->IDLE at T+34.
REQ-019 Special cases (divisor=0, or signed with dividend=0x80000000 and divisor=0xFFFFFFFF): IDLE->DONE at T+1; DONE->IDLE at T+2; no CALC cycles.
REQ-020 Algorithm: radix-2 restoring, one quotient bit per CALC cycle, on a 33-bit partial remainder and a 32-bit shifting dividend/quotient register.
REQ-021 Signed ops SHALL divide magnitudes; quotient negated iff sign(rs1) XOR sign(rs2); remainder takes the sign of rs1; unsigned ops SHALL skip all sign handling.
REQ-022 Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend, unchanged (signed and unsigned).
REQ-023 Signed overflow: quotient = 0x80000000; remainder = 0.
REQ-024 div_wb_valid = (state==DONE) & ~pipe_flush & (latched rd_addr != 0).
REQ-025 div_wb_data and div_wb_rd_addr SHALL be stable for the whole DONE cycle; outside DONE they hold their last value.
REQ-026 pipe_flush=1 in CALC or DONE: state SHALL be IDLE at the next edge and no write-back SHALL occur; exu_div_busy is 0 the following cycle.
REQ-027 A divide with rd_addr=0 SHALL still run the full FSM sequence and assert busy, with div_wb_valid held at 0.
REQ-028 div_wb_data SHALL depend only on latched operands, never on live rs1_data/rs2_data after acceptance.

Reset
REQ-029 rstn=0 SHALL immediately force state=IDLE, exu_div_busy=0, div_wb_valid=0, div_wb_data=0, div_wb_rd_addr=0, and clear the counter and datapath registers.
REQ-030 Reset asserted mid-CALC SHALL abort the divide with no write-back; the first div_valid after rstn deasserts SHALL be accepted normally.

Verification
REQ-031 DIV 100/7, rd=x5, accepted at T -> busy 1 T+1..T+33; div_wb_valid=1 at T+33 only, data=14, rd=5; busy 0 at T+34.
REQ-032 REM -100 % 7 (rs1=0xFFFFFF9C, signed) -> data 0xFFFFFFFE at T+33; DIV same operands -> 0xFFFFFFF2.
REQ-033 DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1; signed DIV of the same operands -> 0x00000000.
REQ-034 DIV 5/0 -> 0xFFFFFFFF at T+1, busy only at T+1; REM 5%0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0.
REQ-035 pipe_flush at T+10 of a DIV -> no div_wb_valid, busy 0 from T+11; new DIV 9/3 at T+11 -> data 3 at T+44.
REQ-036 Back-to-back: second div_valid held during busy -> ignored until IDLE, then accepted; rd_addr=0 divide -> busy for 33 cycles, div_wb_valid never 1; rstn pulse at T+5 -> all outputs 0 immediately.

Source files
------------

// File: rtl/exu_div.sv
// exu_div: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with flush and write-back.
// Divide-by-zero and signed overflow skip the iteration and finish in a single DONE cycle.
module exu_div (
    input  logic        clk,
    input  logic        rstn,
    input  logic        div_valid,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        rs1_sign,
    input  logic        rem,
    input  logic [4:0]  rd_addr,
    input  logic        pipe_flush,
    output logic        exu_div_busy,
    output logic        div_wb_valid,
    output logic [31:0] div_wb_data,
    output logic [4:0]  div_wb_rd_addr
);
    localparam int XLEN = 32;
    localparam int REG_FILE_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                         state_q, state_d;
    logic [4:0]                     cnt_q, cnt_d;
    logic [XLEN-1:0]                prem_q, prem_d;
    logic [XLEN-1:0]                quo_q, quo_d;
    logic [XLEN-1:0]                dvsr_q, dvsr_d;
    logic [XLEN-1:0]                data_q, data_d;
    logic                           neg_quo_q, neg_quo_d;
    logic                           neg_rem_q, neg_rem_d;
    logic                           rem_sel_q, rem_sel_d;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;

    logic            a_neg, b_neg, div0, ovf, ge;
    logic [XLEN-1:0] a_mag, b_mag, step_q, step_r, res, spec_res;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        a_neg    = rs1_sign & rs1_data[XLEN-1];
        b_neg    = rs1_sign & rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div0     = rs2_data == '0;
        ovf      = rs1_sign & (rs1_data == 32'h8000_0000) & (&rs2_data);
        spec_res = div0 ? (rem ? rs1_data : '1) : (rem ? '0 : 32'h8000_0000);
        // 33-bit partial remainder: shift in the next dividend bit, trial-subtract the divisor
        shifted  = {prem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, dvsr_q};
        ge       = ~diff[XLEN];
        step_r   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        step_q   = {quo_q[XLEN-2:0], ge};
        res      = rem_sel_q ? (neg_rem_q ? -step_r : step_r) : (neg_quo_q ? -step_q : step_q);
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        data_d    = data_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        rd_d      = rd_q;
        wb_rd_d   = wb_rd_q;
        case (state_q)
            IDLE: if (div_valid && !pipe_flush) begin
                rem_sel_d = rem;
                rd_d      = rd_addr;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                if (div0 || ovf) begin
                    state_d = DONE;
                    data_d  = spec_res;
                    wb_rd_d = rd_addr;
                end else begin
                    state_d = CALC;
                    cnt_d   = '0;
                    prem_d  = '0;
                    quo_d   = a_mag;
                    dvsr_d  = b_mag;
                end
            end
            CALC: if (pipe_flush) begin
                state_d = IDLE;
            end else begin
                prem_d = step_r;
                quo_d  = step_q;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    data_d  = res;
                    wb_rd_d = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            data_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            data_q    <= data_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

    assign exu_div_busy   = state_q != IDLE;
    assign div_wb_valid   = (state_q == DONE) && !pipe_flush && (wb_rd_q != '0);
    assign div_wb_data    = data_q;
    assign div_wb_rd_addr = wb_rd_q;
endmodule

// File: tb/tb_exu_div.sv
// tb_exu_div: directed self-checking bench for exu_div covering normal, special, flush, back-to-back and reset cases.
module tb_exu_div;
    logic        clk, rstn, div_valid, rs1_sign, rem, pipe_flush;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_addr;
    logic        exu_div_busy, div_wb_valid;
    logic [31:0] div_wb_data;
    logic [4:0]  div_wb_rd_addr;
    int n_cmp = 0;
    int n_err = 0;

    exu_div dut (
        .clk(clk), .rstn(rstn), .div_valid(div_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_sign(rs1_sign), .rem(rem), .rd_addr(rd_addr), .pipe_flush(pipe_flush),
        .exu_div_busy(exu_div_busy), .div_wb_valid(div_wb_valid),
        .div_wb_data(div_wb_data), .div_wb_rd_addr(div_wb_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Observe cycles T+1..T+lat+1 after an accept edge; result expected only in cycle T+lat.
    task automatic watch(input int lat, input logic [4:0] rd, input logic [31:0] exp, input string tag);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(exu_div_busy), 32'(c <= lat));
            chk({tag, "_valid"}, 32'(div_wb_valid), 32'(c == lat && rd != 5'd0));
            if (c == lat && rd != 5'd0) begin
                chk({tag, "_data"}, div_wb_data, exp);
                chk({tag, "_rd"}, 32'(div_wb_rd_addr), 32'(rd));
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                         input logic [4:0] rd, input string tag);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(exu_div_busy), 32'd0);
        div_valid = 1'b1; rs1_data = a; rs2_data = b; rs1_sign = s; rem = r; rd_addr = rd;
        @(posedge clk); #1;
        div_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rs1_sign = ~s; rem = ~r;
        rd_addr = 5'($urandom);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat, input string tag);
        issue(a, b, s, r, rd, tag);
        watch(lat, rd, exp, tag);
    endtask

    initial begin
        rstn = 1'b1; div_valid = 1'b0; rs1_data = '0; rs2_data = '0; rs1_sign = 1'b0; rem = 1'b0;
        rd_addr = '0; pipe_flush = 1'b0;
        #1 rstn = 1'b0;
        #2;
        chk("rst_busy", 32'(exu_div_busy), 32'd0);
        chk("rst_valid", 32'(div_wb_valid), 32'd0);
        chk("rst_data", div_wb_data, 32'd0);
        chk("rst_rd", 32'(div_wb_rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        do_div(32'd100, 32'd7, 1'b1, 1'b0, 5'd5, 32'd14, 33, "div_100_7");
        do_div(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 5'd8, 32'hFFFF_FFFE, 33, "rem_m100_7");
        do_div(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFF2, 33, "div_m100_7");
        do_div(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 5'd10, 32'h7FFF_FFFF, 33, "divu_max_2");
        do_div(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5'd11, 32'd1, 33, "remu_max_2");
        do_div(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 5'd12, 32'd0, 33, "div_m1_2");
        do_div(32'd5, 32'd0, 1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF, 1, "div_5_0");
        do_div(32'd5, 32'd0, 1'b1, 1'b1, 5'd14, 32'd5, 1, "rem_5_0");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd15, 32'h8000_0000, 1, "div_ovf");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd16, 32'd0, 1, "rem_ovf");

        // Flush at T+10, then a new divide accepted at T+11
        issue(32'd50, 32'd5, 1'b0, 1'b0, 5'd3, "flush");
        repeat (9) @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush_busy_t10", 32'(exu_div_busy), 32'd1);
        pipe_flush = 1'b1;
        @(posedge clk); #1;
        pipe_flush = 1'b0;
        do_div(32'd9, 32'd3, 1'b1, 1'b0, 5'd4, 32'd3, 33, "flush_next");

        // Second request held while busy is ignored until IDLE, then accepted
        issue(32'd20, 32'd4, 1'b0, 1'b0, 5'd6, "b2b_a");
        div_valid = 1'b1; rs1_data = 32'd81; rs2_data = 32'd9; rs1_sign = 1'b0; rem = 1'b0; rd_addr = 5'd7;
        watch(33, 5'd6, 32'd5, "b2b_a");
        @(posedge clk); #1;
        div_valid = 1'b0; rs1_data = 32'd1; rs2_data = 32'd1;
        watch(33, 5'd7, 32'd9, "b2b_b");

        do_div(32'd12, 32'd3, 1'b0, 1'b0, 5'd0, 32'd4, 33, "rd0");

        // Reset pulse mid-divide at T+5
        issue(32'd100, 32'd7, 1'b1, 1'b0, 5'd5, "rstpulse");
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rstpulse_busy", 32'(exu_div_busy), 32'd0);
        chk("rstpulse_valid", 32'(div_wb_valid), 32'd0);
        chk("rstpulse_data", div_wb_data, 32'd0);
        chk("rstpulse_rd", 32'(div_wb_rd_addr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            chk("rstpulse_nowb", 32'({exu_div_busy, div_wb_valid}), 32'd0);
        end
        do_div(32'd9, 32'd3, 1'b0, 1'b0, 5'd2, 32'd3, 33, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
